// File: rtl/multiply_stream_pipe_pkg.sv
// multiply_stream_pipe_pkg: shared fixed-point dequantise and saturate helpers
package multiply_stream_pipe_pkg;
  localparam int MAX_W = 128;
  function automatic logic signed [MAX_W-1:0] dequantize(input logic signed [MAX_W-1:0] x, input int frac);
    logic signed [MAX_W-1:0] bias;
    bias = x[MAX_W-1] ? (MAX_W'(1) <<< frac) - MAX_W'(1) : '0;
    return (x + bias) >>> frac;
  endfunction
  function automatic logic signed [MAX_W-1:0] saturate(input logic signed [MAX_W-1:0] x, input int w);
    logic signed [MAX_W-1:0] hi, lo;
    hi = (MAX_W'(1) <<< (w - 1)) - MAX_W'(1);
    lo = ~hi;
    return x > hi ? hi : (x < lo ? lo : x);
  endfunction
endpackage

// File: rtl/multiply_stream_pipe_reg.sv
// multiply_pipe_reg: valid/data pipeline register with enable and sync active-low clear
module multiply_pipe_reg #(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_data,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_data
);
  always_ff @(posedge clock)
    if (!reset) begin
      q_valid <= 1'b0;
      q_data  <= '0;
    end else if (en) begin
      q_valid <= d_valid;
      q_data  <= d_data;
    end
endmodule

// File: rtl/multiply_stream_pipe.sv
// multiply_stream_pipe: pipelined fixed-point stream multiplier; define MULTIPLY_SATURATE_EN to clamp results and count saturations
module multiply_stream_pipe
  import multiply_stream_pipe_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int FRAC_BITS   = 10,
  parameter int PIPE_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  inA_rd_en,
  input  logic                  inA_empty,
  input  logic [DATA_WIDTH-1:0] inA_dout,
  output logic                  inB_rd_en,
  input  logic                  inB_empty,
  input  logic [DATA_WIDTH-1:0] inB_dout,
  output logic                  out_wr_en,
  input  logic                  out_full,
  output logic [DATA_WIDTH-1:0] out_din,
  output logic [15:0]           sat_count
);
  localparam int PW = 2 * DATA_WIDTH;
`ifdef MULTIPLY_SATURATE_EN
  localparam int RW = DATA_WIDTH + 1;
`else
  localparam int RW = DATA_WIDTH;
`endif
  logic [PIPE_STAGES-1:0] v;
  logic                   advance, pop;
  logic signed [PW-1:0]   prod;
  logic [RW-1:0]          res;
  assign advance   = !(v[PIPE_STAGES-1] && out_full);
  assign pop       = reset && advance && !inA_empty && !inB_empty;
  assign inA_rd_en = pop;
  assign inB_rd_en = pop;
  assign prod      = PW'($signed(inA_dout)) * PW'($signed(inB_dout));
  for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
    localparam int W = (i == PIPE_STAGES - 1) ? RW : PW;
    logic signed [PW-1:0] src;
    logic [W-1:0]         d, q;
    logic                 vin;
    if (i == 0) begin : g_first
      assign src = prod;
      assign vin = pop;
    end else begin : g_next
      assign src = g_stage[i-1].q;
      assign vin = v[i-1];
    end
    if (i == PIPE_STAGES - 1) begin : g_last
`ifdef MULTIPLY_SATURATE_EN
      logic signed [MAX_W-1:0] dq;
      assign dq = dequantize(MAX_W'(src), FRAC_BITS);
      assign d  = {saturate(dq, DATA_WIDTH) != dq, DATA_WIDTH'(saturate(dq, DATA_WIDTH))};
`else
      assign d = DATA_WIDTH'(dequantize(MAX_W'(src), FRAC_BITS));
`endif
    end else begin : g_mid
      assign d = src;
    end
    multiply_pipe_reg #(.WIDTH(W)) u_reg (
      .clock  (clock),
      .reset  (reset),
      .en     (advance),
      .d_valid(vin),
      .d_data (d),
      .q_valid(v[i]),
      .q_data (q)
    );
  end
  assign res       = g_stage[PIPE_STAGES-1].q;
  assign out_wr_en = reset && v[PIPE_STAGES-1] && !out_full;
  assign out_din   = out_wr_en ? res[DATA_WIDTH-1:0] : '0;
`ifdef MULTIPLY_SATURATE_EN
  always_ff @(posedge clock)
    if (!reset) sat_count <= '0;
    else if (out_wr_en && res[DATA_WIDTH] && sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
`else
  assign sat_count = '0;
`endif
endmodule
